ts_derandomizer: RTL and testbench
==================================

TS_DERANDOMIZER -- requirements
Module: ts_derandomizer

Interface
REQ-001 Parameter LOSS_THR, default 3: number of consecutive bad group-start sync bytes that drops lock.
REQ-002 Parameter PRBS_INIT, default 15'b100101010000000: PRBS register load value, bit 1 first.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 CE  input  1  byte strobe from the RS decoder CEO output; one-clock pulse per byte.
REQ-006 Valid_in  input  1  RS decoder Valid_out; a byte is accepted only when CE && Valid_in.
REQ-007 input_byte  input  8  decoded byte (188-byte packets, sync byte first).
REQ-008 Out_byte  output  8  derandomized byte; held between strobes.
REQ-009 CEO  output  1  one-clock pulse per output byte.
REQ-010 Valid_out  output  1  qualifies Out_byte/CEO; high only while locked.
REQ-011 Sync_out  output  1  high with CEO on packet byte 0.

Function
REQ-012 Accepted byte (CE && Valid_in) SHALL produce CEO exactly 1 clk later, with Out_byte, Valid_out and Sync_out registered in that same cycle.
REQ-013 Byte counter 0..187 SHALL advance per accepted byte and wrap 187->0; packet counter 0..7 SHALL advance on that wrap, 7->0.
REQ-014 Both counters SHALL clear to 0 when Valid_in is low at a CE strobe (decoder block gap or error).
REQ-015 FSM states: HUNT, LOCKED.
REQ-016 HUNT: on accepted byte with byte counter 0 and value 8'hB8 -> LOCKED; packet counter forced to 0; PRBS loaded with PRBS_INIT; Out_byte=8'h47.
REQ-017 HUNT: all other bytes give CEO pulses with Valid_out=0 and Out_byte=input_byte.
REQ-018 LOCKED, byte 0 of packet 0: 8'hB8 -> output 8'h47, reload PRBS, clear miss counter; other value -> output unchanged, increment miss counter, PRBS reloaded anyway.
REQ-019 Miss counter reaching LOSS_THR SHALL return FSM to HUNT; the byte that trips it is output with Valid_out=0.
REQ-020 LOCKED, byte 0 of packets 1..7: byte passed unchanged (not XORed); PRBS SHALL still advance 8 steps.
REQ-021 LOCKED, bytes 1..187: Out_byte = input_byte XOR next 8 PRBS bits, first bit into MSB; PRBS advances 8 steps.
REQ-022 PRBS polynomial 1 + x^14 + x^15; output bit = r14 XOR r15, fed back into r1; period 1503 bytes per group.
REQ-023 CE without Valid_in SHALL NOT advance PRBS or counters (other than clearing them, REQ-014) and SHALL produce no CEO.

Reset
REQ-024 On reset low: FSM=HUNT; counters, miss counter, PRBS register = 0; Out_byte=0; CEO, Valid_out, Sync_out = 0.
REQ-025 Reset asserted mid-packet SHALL take effect immediately; the next lock requires a fresh 8'hB8 at byte 0.

Configuration
REQ-026 Macro TS_DERAND_STATS_EN: when defined, output port lock_loss_cnt [7:0] exists, increments on every LOCKED->HUNT transition, saturates at 8'hFF, and is cleared by reset.
REQ-027 Without TS_DERAND_STATS_EN: no lock_loss_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-028 Package ts_derand_pkg SHALL hold SYNC_BYTE=8'h47, SYNC_INV=8'hB8, PKT_LEN=188, GRP_LEN=8, and the PRBS_INIT default.
REQ-029 Sub-module prbs_byte_gen SHALL be purely combinational: it maps a 15-bit state to an 8-bit keystream and the next state after 8 steps; ts_derandomizer holds the state register.

Verification
REQ-030 Lock: packet starting 8'hB8 followed by all-zero payload -> Out_byte 8'h47 then 8'h03, 8'hF6, ...; Valid_out=1; Sync_out on the first CEO.
REQ-031 Round trip: 8 packets scrambled by a reference model, fed with CE every 8 clks -> output equals the original packets, bytes 0 all 8'h47, no errors.
REQ-032 Loss: 3 groups whose byte 0 is 8'h47 instead of 8'hB8 -> Valid_out drops on the third; with TS_DERAND_STATS_EN, lock_loss_cnt=1.
REQ-033 Valid_in low for one strobe mid-packet -> counters clear; no CEO for that strobe; relock on the next 8'hB8.
REQ-034 Reset low at byte 100 -> all outputs 0 within 1 clk; output stays invalid until the next 8'hB8 at byte 0.
REQ-035 Latency: each accepted strobe -> CEO exactly 1 clk later; total CEO count equals accepted byte count.

Source files
------------

// File: rtl/ts_derand_pkg.sv
// ============================================================================
// Module : ts_derand_pkg
// Brief  : Shared constants, FSM state type and PRBS step for ts_derandomizer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ts_derand_pkg;

  localparam logic [7:0]  SYNC_BYTE         = 8'h47;
  localparam logic [7:0]  SYNC_INV          = 8'hB8;
  localparam int          PKT_LEN           = 188;
  localparam int          GRP_LEN           = 8;
  // Leftmost literal bit is r1, so r1 = state[14] and r15 = state[0].
  localparam logic [14:0] PRBS_INIT_DEFAULT = 15'b100101010000000;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // One shift of the 1 + x^14 + x^15 generator: output r14^r15 feeds r1.
  function automatic logic [14:0] prbs_step(input logic [14:0] s);
    return {s[1] ^ s[0], s[14:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs_byte_gen.sv
// ============================================================================
// Module : prbs_byte_gen
// Brief  : Combinational 8-step PRBS advance; first generated bit lands in MSB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prbs_byte_gen
  import ts_derand_pkg::*;
(
  input  logic [14:0] state,
  output logic [7:0]  keystream,
  output logic [14:0] next_state
);

  logic [14:0] s;

  always_comb begin
    s         = state;
    keystream = '0;
    for (int i = 7; i >= 0; i--) begin
      keystream[i] = s[1] ^ s[0];
      s            = prbs_step(s);
    end
    next_state = s;
  end

endmodule

`default_nettype wire

// File: rtl/ts_derandomizer.sv
// ============================================================================
// Module : ts_derandomizer
// Brief  : DVB transport-stream derandomizer with sync-inverted group lock.
//          Optional lock-loss statistics counter when TS_DERAND_STATS_EN is set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ts_derandomizer
  import ts_derand_pkg::*;
#(
  parameter int          LOSS_THR  = 3,
  parameter logic [14:0] PRBS_INIT = PRBS_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic       Valid_in,
  input  logic [7:0] input_byte,
  output logic [7:0] Out_byte,
  output logic       CEO,
  output logic       Valid_out,
  output logic       Sync_out
`ifdef TS_DERAND_STATS_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int         MISS_W    = $clog2(LOSS_THR + 1);
  localparam logic [7:0] BYTE_LAST = 8'(PKT_LEN - 1);
  localparam logic [2:0] PKT_LAST  = 3'(GRP_LEN - 1);

  state_t              state;
  logic [7:0]          byte_cnt;
  logic [2:0]          pkt_cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic [14:0]         prbs;

  logic [7:0]          keystream;
  logic [14:0]         prbs_next;
  logic                accept;
  logic                gap;
  logic                at_pkt_start;
  logic                at_grp_start;
  logic                is_sync_inv;
  logic [MISS_W-1:0]   miss_inc;
  logic                lose_lock;

  prbs_byte_gen u_prbs (
    .state      (prbs),
    .keystream  (keystream),
    .next_state (prbs_next)
  );

  assign accept       = CE & Valid_in;
  assign gap          = CE & ~Valid_in;
  assign at_pkt_start = (byte_cnt == 8'd0);
  assign at_grp_start = at_pkt_start && (pkt_cnt == 3'd0);
  assign is_sync_inv  = (input_byte == SYNC_INV);
  assign miss_inc     = miss_cnt + MISS_W'(1);
  assign lose_lock    = accept && (state == LOCKED) && at_grp_start &&
                        !is_sync_inv && (miss_inc >= MISS_W'(LOSS_THR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      byte_cnt  <= '0;
      pkt_cnt   <= '0;
      miss_cnt  <= '0;
      prbs      <= '0;
      Out_byte  <= '0;
      CEO       <= 1'b0;
      Valid_out <= 1'b0;
      Sync_out  <= 1'b0;
    end else begin
      CEO      <= accept;
      Sync_out <= 1'b0;
      if (gap) begin
        byte_cnt <= '0;
        pkt_cnt  <= '0;
      end else if (accept) begin
        if (byte_cnt == BYTE_LAST) begin
          byte_cnt <= '0;
          pkt_cnt  <= (pkt_cnt == PKT_LAST) ? 3'd0 : pkt_cnt + 3'd1;
        end else begin
          byte_cnt <= byte_cnt + 8'd1;
        end

        case (state)
          HUNT: begin
            if (at_pkt_start && is_sync_inv) begin
              state     <= LOCKED;
              pkt_cnt   <= '0;
              prbs      <= PRBS_INIT;
              miss_cnt  <= '0;
              Out_byte  <= SYNC_BYTE;
              Valid_out <= 1'b1;
              Sync_out  <= 1'b1;
            end else begin
              Out_byte  <= input_byte;
              Valid_out <= 1'b0;
            end
          end

          LOCKED: begin
            if (at_grp_start) begin
              // The generator restarts every group, even on a missed sync.
              prbs <= PRBS_INIT;
              if (is_sync_inv) begin
                miss_cnt  <= '0;
                Out_byte  <= SYNC_BYTE;
                Valid_out <= 1'b1;
                Sync_out  <= 1'b1;
              end else if (lose_lock) begin
                state     <= HUNT;
                miss_cnt  <= '0;
                Out_byte  <= input_byte;
                Valid_out <= 1'b0;
              end else begin
                miss_cnt  <= miss_inc;
                Out_byte  <= input_byte;
                Valid_out <= 1'b1;
                Sync_out  <= 1'b1;
              end
            end else if (at_pkt_start) begin
              // Plain sync bytes are not scrambled but still consume keystream.
              prbs      <= prbs_next;
              Out_byte  <= input_byte;
              Valid_out <= 1'b1;
              Sync_out  <= 1'b1;
            end else begin
              prbs      <= prbs_next;
              Out_byte  <= input_byte ^ keystream;
              Valid_out <= 1'b1;
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef TS_DERAND_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_loss_cnt <= '0;
    end else if (lose_lock && (lock_loss_cnt != 8'hFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ts_derandomizer.sv
// ============================================================================
// Module : tb_ts_derandomizer
// Brief  : Scoreboard bench for ts_derandomizer against a group-position model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ts_derandomizer;

  localparam int THR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       CE;
  logic       Valid_in;
  logic [7:0] input_byte;
  logic [7:0] Out_byte;
  logic       CEO;
  logic       Valid_out;
  logic       Sync_out;
`ifdef TS_DERAND_STATS_EN
  logic [7:0] lock_loss_cnt;
`endif

  ts_derandomizer #(.LOSS_THR(THR)) dut (
    .clk        (clk),
    .reset      (reset),
    .CE         (CE),
    .Valid_in   (Valid_in),
    .input_byte (input_byte),
    .Out_byte   (Out_byte),
    .CEO        (CEO),
    .Valid_out  (Valid_out),
    .Sync_out   (Sync_out)
`ifdef TS_DERAND_STATS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic       s;
    longint     due;
  } exp_t;

  exp_t       q[$];
  logic [7:0] obs[$];
  logic [7:0] orig_q[$];
  logic [7:0] key [0:1502];

  int     n_cmp = 0;
  int     n_err = 0;
  int     n_acc = 0;
  int     n_ceo = 0;
  longint cyc   = 0;

  // Reference state: position within the 1504-byte group, lock and misses.
  bit m_locked;
  int m_pos;
  int m_miss;
  int m_loss;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Keystream straight from the shift-register definition, r1..r15.
  task automatic build_key();
    bit r[1:15];
    logic [14:0] init;
    bit fb;
    init = 15'b100101010000000;
    for (int i = 1; i <= 15; i++) r[i] = init[15-i];
    for (int n = 0; n < 1503; n++) begin
      key[n] = 8'h00;
      for (int k = 7; k >= 0; k--) begin
        fb = r[14] ^ r[15];
        key[n][k] = fb;
        for (int j = 15; j >= 2; j--) r[j] = r[j-1];
        r[1] = fb;
      end
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_pos    = 0;
    m_miss   = 0;
    m_loss   = 0;
  endtask

  function automatic void model(input bit v, input logic [7:0] b, input longint due);
    exp_t e;
    int bpos;
    if (!v) begin
      m_pos = 0;
      return;
    end
    bpos = m_pos % 188;
    e.due = due;
    e.s   = 1'b0;
    if (!m_locked) begin
      if (bpos == 0 && b == 8'hB8) begin
        m_locked = 1; m_miss = 0; m_pos = 0;
        e.b = 8'h47; e.v = 1'b1; e.s = 1'b1;
      end else begin
        e.b = b; e.v = 1'b0;
      end
    end else if (m_pos == 0) begin
      if (b == 8'hB8) begin
        m_miss = 0;
        e.b = 8'h47; e.v = 1'b1; e.s = 1'b1;
      end else begin
        m_miss++;
        e.b = b;
        if (m_miss >= THR) begin
          m_locked = 0; m_miss = 0;
          if (m_loss < 255) m_loss++;
          e.v = 1'b0;
        end else begin
          e.v = 1'b1; e.s = 1'b1;
        end
      end
    end else if (bpos == 0) begin
      e.b = b; e.v = 1'b1; e.s = 1'b1;
    end else begin
      e.b = b ^ key[m_pos-1]; e.v = 1'b1;
    end
    m_pos = (m_pos + 1) % 1504;
    n_acc++;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && CEO === 1'b1) begin
      exp_t e;
      n_ceo++;
      obs.push_back(Out_byte);
      if (q.size() == 0) begin
        check("unexpected_ceo", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_byte", Out_byte, e.b);
        check("valid_out", Valid_out, e.v);
        check("sync_out", Sync_out, e.s);
        check("ceo_latency", cyc, e.due);
      end
    end
  end

  task automatic strobe(input bit v, input logic [7:0] b, input int idle);
    @(negedge clk);
    CE = 1'b1; Valid_in = v; input_byte = b;
    model(v, b, cyc + 1);
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      CE = 1'b0; Valid_in = $urandom_range(0, 1); input_byte = 8'($urandom);
    end
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    CE = 1'b0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Scrambles a group of random packets; idle < 0 picks random spacing.
  task automatic send_group(input bit good, input int idle, input int nbytes, input bit randgap);
    logic [7:0] o;
    logic [7:0] s;
    int p;
    int i;
    for (int k = 0; k < nbytes; k++) begin
      p = k / 188;
      i = k % 188;
      o = (i == 0) ? 8'h47 : 8'($urandom);
      if (p == 0 && i == 0) s = good ? 8'hB8 : 8'h47;
      else if (i == 0)      s = 8'h47;
      else                  s = o ^ key[p*188 + i - 1];
      if (randgap && $urandom_range(0, 299) == 0)
        strobe(1'b0, 8'($urandom), $urandom_range(0, 2));
      orig_q.push_back(o);
      strobe(1'b1, s, (idle < 0) ? $urandom_range(0, 3) : idle);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_byte"}, Out_byte, 0);
    check({tag, "_ceo"}, CEO, 0);
    check({tag, "_valid_out"}, Valid_out, 0);
    check({tag, "_sync_out"}, Sync_out, 0);
`ifdef TS_DERAND_STATS_EN
    check({tag, "_lock_loss_cnt"}, lock_loss_cnt, 0);
`endif
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; CE = 1'b0; Valid_in = 1'b0; input_byte = 8'h00;
    build_key();
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b1;

    // Lock on an all-zero payload; first keystream bytes are visible directly.
    obs.delete();
    strobe(1'b1, 8'hB8, 1);
    for (int k = 1; k < 188; k++) strobe(1'b1, 8'h00, 1);
    drain();
    check("lock_first_byte", obs[0], 8'h47);
    check("lock_key_byte1", obs[1], 8'h03);
    check("lock_key_byte2", obs[2], 8'hF6);
    for (int k = 188; k < 1504; k++) strobe(1'b1, 8'h00, 0);
    drain();

    // Round trip at one strobe per 8 clocks.
    obs.delete(); orig_q.delete();
    send_group(1'b1, 7, 1504, 1'b0);
    drain();
    check("roundtrip_count", obs.size(), 1504);
    for (int k = 0; k < 1504 && k < obs.size(); k++)
      check("roundtrip_byte", obs[k], orig_q[k]);

    // Three bad group starts drop lock, then a good group relocks.
    for (int g = 0; g < 3; g++) send_group(1'b0, 0, 1504, 1'b0);
    drain();
    check("loss_valid_low", Valid_out, 0);
`ifdef TS_DERAND_STATS_EN
    check("loss_stat", lock_loss_cnt, 1);
`endif
    send_group(1'b1, 0, 1504, 1'b0);

    // Gap strobe mid-packet clears the counters.
    send_group(1'b1, 1, 50, 1'b0);
    strobe(1'b0, 8'h5A, 2);
    send_group(1'b1, 0, 1504, 1'b0);
    drain();
    check("gap_relock_valid", Valid_out, 1);

    // Reset at byte 100 of a locked packet.
    send_group(1'b1, 1, 100, 1'b0);
    drain();
    #2 reset = 1'b0;
    #1 check_zero_outputs("midreset");
    q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 188; k++) strobe(1'b1, (k == 0) ? 8'h47 : 8'($urandom), 0);
    drain();
    check("postreset_invalid", Valid_out, 0);
    send_group(1'b1, 0, 1504, 1'b0);

    // Randomized traffic with spacing, occasional gaps and bad syncs.
    for (int g = 0; g < 4; g++)
      send_group($urandom_range(0, 3) != 0, -1, 1504, 1'b1);
    drain();

    check("ceo_count", n_ceo, n_acc);
`ifdef TS_DERAND_STATS_EN
    check("final_loss_stat", lock_loss_cnt, m_loss);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
